alu_resp_checker: RTL and testbench

// Synthesizable response checker at the receiving end of the ALU stimulus interface. It samples each

---
 rtl/alu_resp_checker.sv | 161 ++++++++++++++++
 tb/tb_alu_resp_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_resp_checker.sv
// alu_resp_checker: recomputes ALU results LAT cycles after each stimulus and tallies mismatches.
// Optional ALU_CHK_HALT_EN: stop the run at the first mismatch.
module alu_resp_checker #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_tests,
    input  logic             stim_valid,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] test_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [3:0]       first_err_ctl,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] n_tgt;
    logic [CNT_W-1:0] issued;
    logic             err_seen;
    logic             halt;
    logic             load;
    logic             take;
    logic             chk;
    logic             flush;
    logic             bad;
    logic             mism;
    logic [WIDTH-1:0] exp;

    logic [LAT-1:0]   pv;
    logic [3:0]       p_ctl [LAT];
    logic [WIDTH-1:0] p_a   [LAT];
    logic [WIDTH-1:0] p_b   [LAT];

`ifdef ALU_CHK_HALT_EN
    assign halt = err_seen;
`else
    assign halt = 1'b0;
`endif

    assign load  = start && (state != RUN);
    assign take  = (state == RUN) && stim_valid && (issued < n_tgt) && !halt;
    assign chk   = (state == RUN) && pv[LAT-1] && !halt;
    assign flush = (state_nxt != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (num_tests == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if ((test_cnt == n_tgt) || halt) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stimulus delay line aligning {ctl,a,b} with the ALU response
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pv <= '0;
        end else begin
            pv[0] <= take;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
            end
        end
        p_ctl[0] <= ctl;
        p_a[0]   <= a;
        p_b[0]   <= b;
        for (int i = 1; i < LAT; i++) begin
            p_ctl[i] <= p_ctl[i-1];
            p_a[i]   <= p_a[i-1];
            p_b[i]   <= p_b[i-1];
        end
    end

    always_comb begin
        exp = '0;
        bad = 1'b0;
        case (p_ctl[LAT-1])
            4'd0: exp = p_a[LAT-1] + p_b[LAT-1];
            4'd1: exp = p_a[LAT-1] - p_b[LAT-1];
            4'd2: exp = p_a[LAT-1] & p_b[LAT-1];
            4'd3: exp = ~(p_a[LAT-1] | p_b[LAT-1]);
            4'd4: exp = p_a[LAT-1] | p_b[LAT-1];
            4'd5: exp = {{(WIDTH-1){1'b0}},
                         $signed(p_a[LAT-1]) < $signed(p_b[LAT-1])};
            4'd6: exp = p_a[LAT-1] ^ p_b[LAT-1];
            default: bad = 1'b1;
        endcase
    end

    assign mism = bad || (alu_out != exp) || (alu_zero != (exp == '0));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            n_tgt         <= rst ? '0 : num_tests;
            issued        <= '0;
            test_cnt      <= '0;
            err_cnt       <= '0;
            err_seen      <= 1'b0;
            first_err_idx <= '0;
            first_err_ctl <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else begin
            if (take) begin
                issued <= issued + 1'b1;
            end
            if (chk) begin
                test_cnt <= test_cnt + 1'b1;
                if (mism) begin
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    if (!err_seen) begin
                        err_seen      <= 1'b1;
                        first_err_idx <= test_cnt;
                        first_err_ctl <= p_ctl[LAT-1];
                        first_err_exp <= exp;
                        first_err_got <= alu_out;
                    end
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_alu_resp_checker.sv
// Directed bench for alu_resp_checker (LAT=1): the bench plays the ALU with hand-computed results.
module tb_alu_resp_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_tests;
    logic        stim_valid;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] test_cnt;
    logic [15:0] err_cnt;
    logic [15:0] first_err_idx;
    logic [3:0]  first_err_ctl;
    logic [31:0] first_err_exp;
    logic [31:0] first_err_got;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_resp_checker #(.WIDTH(32), .CNT_W(16), .LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tests(num_tests),
        .stim_valid(stim_valid), .ctl(ctl), .a(a), .b(b),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .busy(busy), .done(done), .pass(pass),
        .test_cnt(test_cnt), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .first_err_ctl(first_err_ctl),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run(input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        num_tests = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Stimulus cycle, then the ALU answer presented the following cycle
    task automatic send(input logic [3:0] c, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] o,
                        input logic z);
        @(negedge clk);
        stim_valid = 1'b1;
        ctl = c;
        a = x;
        b = y;
        @(negedge clk);
        stim_valid = 1'b0;
        alu_out = o;
        alu_zero = z;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done", {63'd0, done}, 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_tests = '0;
        stim_valid = 1'b0;
        ctl = '0;
        a = '0;
        b = '0;
        alu_out = '0;
        alu_zero = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_pass", {63'd0, pass}, 64'd0);
        chk("rst_tcnt", {48'd0, test_cnt}, 64'd0);
        rst = 1'b0;

        // all seven ops, correct ALU
        run(16'd7);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        send(4'd0, 32'd5, 32'd3, 32'd8, 1'b0);
        send(4'd1, 32'd5, 32'd3, 32'd2, 1'b0);
        send(4'd2, 32'd5, 32'd3, 32'd1, 1'b0);
        send(4'd3, 32'd5, 32'd3, 32'hFFFF_FFF8, 1'b0);
        send(4'd4, 32'd5, 32'd3, 32'd7, 1'b0);
        send(4'd5, 32'd5, 32'd3, 32'd0, 1'b1);
        send(4'd6, 32'd5, 32'd3, 32'd6, 1'b0);
        wait_done();
        chk("t1_tcnt", {48'd0, test_cnt}, 64'd7);
        chk("t1_ecnt", {48'd0, err_cnt}, 64'd0);
        chk("t1_pass", {63'd0, pass}, 64'd1);
        chk("t1_busy_off", {63'd0, busy}, 64'd0);

        // zero flag: correct then forced wrong
        run(16'd2);
        send(4'd1, 32'd9, 32'd9, 32'd0, 1'b1);
        send(4'd1, 32'd9, 32'd9, 32'd0, 1'b0);
        wait_done();
        chk("t2_ecnt", {48'd0, err_cnt}, 64'd1);
        chk("t2_idx", {48'd0, first_err_idx}, 64'd1);
        chk("t2_ctl", {60'd0, first_err_ctl}, 64'd1);
        chk("t2_exp", {32'd0, first_err_exp}, 64'd0);
        chk("t2_pass", {63'd0, pass}, 64'd0);

        // signed SLT and ADD wrap
        run(16'd2);
        send(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        send(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        wait_done();
        chk("t3_tcnt", {48'd0, test_cnt}, 64'd2);
        chk("t3_ecnt", {48'd0, err_cnt}, 64'd0);
        chk("t3_pass", {63'd0, pass}, 64'd1);

        // 5 stimuli for 3 tests, illegal op second
        run(16'd3);
        send(4'd0, 32'd1, 32'd2, 32'd3, 1'b0);
        send(4'd7, 32'd1, 32'd2, 32'd0, 1'b1);
        send(4'd2, 32'd6, 32'd3, 32'd2, 1'b0);
        send(4'd0, 32'd1, 32'd1, 32'd5, 1'b0);
        send(4'd0, 32'd1, 32'd1, 32'd5, 1'b0);
        wait_done();
        chk("t4_tcnt", {48'd0, test_cnt}, 64'd3);
        chk("t4_ecnt", {48'd0, err_cnt}, 64'd1);
        chk("t4_idx", {48'd0, first_err_idx}, 64'd1);
        chk("t4_ctl", {60'd0, first_err_ctl}, 64'd7);
        chk("t4_exp", {32'd0, first_err_exp}, 64'd0);
        chk("t4_pass", {63'd0, pass}, 64'd0);

        // empty run, then reset mid-run
        run(16'd0);
        chk("t5_done", {63'd0, done}, 64'd1);
        chk("t5_pass", {63'd0, pass}, 64'd1);
        chk("t5_ecnt", {48'd0, err_cnt}, 64'd0);
        chk("t5_ctl", {60'd0, first_err_ctl}, 64'd0);
        run(16'd4);
        send(4'd0, 32'd1, 32'd1, 32'd9, 1'b0);
        @(negedge clk);
        chk("t5_ecnt_pre", {48'd0, err_cnt}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_busy", {63'd0, busy}, 64'd0);
        chk("t5_rst_done", {63'd0, done}, 64'd0);
        chk("t5_rst_ecnt", {48'd0, err_cnt}, 64'd0);
        chk("t5_rst_tcnt", {48'd0, test_cnt}, 64'd0);
        chk("t5_rst_got", {32'd0, first_err_got}, 64'd0);

        // error at test 2 of 10
        run(16'd10);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) send(4'd4, 32'd1, 32'd2, 32'd0, 1'b1);
            else send(4'd4, 32'd1, 32'd2, 32'd3, 1'b0);
        end
        wait_done();
`ifdef ALU_CHK_HALT_EN
        chk("t6_tcnt", {48'd0, test_cnt}, 64'd3);
`else
        chk("t6_tcnt", {48'd0, test_cnt}, 64'd10);
`endif
        chk("t6_ecnt", {48'd0, err_cnt}, 64'd1);
        chk("t6_idx", {48'd0, first_err_idx}, 64'd2);
        chk("t6_exp", {32'd0, first_err_exp}, 64'd3);
        chk("t6_pass", {63'd0, pass}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
